// File: rtl/cpa_pipe_pkg.sv
// cpa_pkg: operation encoding and segment sizing shared by the pipelined CPA
package cpa_pkg;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    function automatic int seg_w(input int width, input int segs);
        return width / segs;
    endfunction
endpackage

// File: rtl/cpa_pipe_if.sv
// cpa_pipe_if: operand and result handshakes of the pipelined CPA
interface cpa_pipe_if #(parameter int WIDTH = 16);
    logic             in_valid, in_ready, cin, sub;
    logic             out_valid, out_ready, cout, ovf, zero;
    logic [WIDTH-1:0] a, b, s;
    modport master(output in_valid, a, b, cin, sub, out_ready,
                   input in_ready, out_valid, s, cout, ovf, zero);
    modport slave(input in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, s, cout, ovf, zero);
endinterface

// File: rtl/cpa_pipe_seg.sv
// cpa_seg: combinational ripple segment exposing carry out and carry into its top bit
module cpa_seg #(parameter int W = 4) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);
    logic [W:0] c;
    always_comb begin
        s = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end
    assign co = c[W];
    assign c_msb = c[W-1];
endmodule

// File: rtl/cpa_pipe.sv
// cpa_pipe: pipelined add/sub resolving one ripple segment per stage under a global stall
module cpa_pipe import cpa_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int SEGS  = 4
) (
    input logic       clk,
    input logic       rst,
    cpa_pipe_if.slave io
);
    localparam int SEG_W = seg_w(WIDTH, SEGS);
    if (SEGS < 1 || SEGS > WIDTH || WIDTH % SEGS != 0) begin : g_chk
        $error("cpa_pipe: WIDTH must be a positive multiple of SEGS");
    end
    logic             en, ovf_q, zero_q;
    logic             vq [SEGS], cq [SEGS], src_v [SEGS], src_c [SEGS], co [SEGS], cm [SEGS];
    logic [WIDTH-1:0] xq [SEGS], bq [SEGS], src_x [SEGS], src_b [SEGS], nx [SEGS], nb [SEGS];
    logic [SEG_W-1:0] sum [SEGS];
    assign en = !vq[SEGS-1] || io.out_ready;
    assign io.in_ready = en;
    assign io.out_valid = vq[SEGS-1];
    assign io.s = xq[SEGS-1];
    assign io.cout = cq[SEGS-1];
    assign io.ovf = ovf_q;
    assign io.zero = zero_q;
    // Words rotate right one segment per stage: the pending operand segment sits at
    // the bottom and each finished sum segment enters at the top, so the last stage
    // holds the result in natural order.
    for (genvar k = 0; k < SEGS; k++) begin : g_st
        if (k == 0) begin : g_in
            assign src_v[k] = io.in_valid;
            assign src_x[k] = io.a;
            assign src_b[k] = io.b ^ {WIDTH{io.sub == OP_SUB}};
            assign src_c[k] = io.sub == OP_SUB ? 1'b1 : io.cin;
        end else begin : g_mid
            assign src_v[k] = vq[k-1];
            assign src_x[k] = xq[k-1];
            assign src_b[k] = bq[k-1];
            assign src_c[k] = cq[k-1];
        end
        cpa_seg #(.W(SEG_W)) u_seg (
            .a(src_x[k][SEG_W-1:0]),
            .b(src_b[k][SEG_W-1:0]),
            .ci(src_c[k]),
            .s(sum[k]),
            .co(co[k]),
            .c_msb(cm[k])
        );
        assign nx[k] = WIDTH'({sum[k], src_x[k]} >> SEG_W);
        assign nb[k] = WIDTH'({src_b[k], src_b[k]} >> SEG_W);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SEGS; k++) begin
                vq[k] <= 1'b0;
                cq[k] <= 1'b0;
                xq[k] <= '0;
                bq[k] <= '0;
            end
            ovf_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < SEGS; k++) begin
                vq[k] <= src_v[k];
                cq[k] <= co[k];
                xq[k] <= nx[k];
                bq[k] <= nb[k];
            end
            ovf_q <= cm[SEGS-1] ^ co[SEGS-1];
            zero_q <= nx[SEGS-1] == '0;
        end
    end
endmodule

// File: tb/tb_cpa_pipe.sv
// tb_cpa_pipe: directed 16-bit vectors plus exhaustive 4-bit sweeps of the pipelined CPA
module tb_cpa_pipe;
    localparam int STAGES = 4;
    logic        clk, rst, go_small;
    int          n_chk, n_err, n_done;
    int          sent, recv, seen;
    logic        prev_stall;
    logic [15:0] held;

    cpa_pipe_if #(.WIDTH(16)) io16 ();
    cpa_pipe #(.WIDTH(16), .SEGS(STAGES)) dut (.clk(clk), .rst(rst), .io(io16));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] model4(input logic [3:0] a, b, input logic ci, su);
        logic [3:0] bb, l;
        logic [4:0] f;
        logic       c0;
        bb = su ? ~b : b;
        c0 = su ? 1'b1 : ci;
        f = {1'b0, a} + {1'b0, bb} + {4'b0, c0};
        l = {1'b0, a[2:0]} + {1'b0, bb[2:0]} + {3'b0, c0};
        return {f[3:0], f[4], l[3] ^ f[4], f[3:0] == 4'd0};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_small
        cpa_pipe_if #(.WIDTH(4)) io ();
        cpa_pipe #(.WIDTH(4), .SEGS(1 << g)) dut4 (.clk(clk), .rst(rst), .io(io));
        initial begin
            logic [6:0] q [$];
            int         ns, nr;
            string      tag;
            io.in_valid = 0;
            io.out_ready = 0;
            {io.a, io.b, io.cin, io.sub} = '0;
            ns = 0;
            nr = 0;
            tag = $sformatf("w4_segs%0d", 1 << g);
            wait (go_small);
            for (int c = 0; c < 8000 && nr < 1024; c++) begin
                @(negedge clk);
                io.in_valid = ns < 1024;
                {io.a, io.b, io.cin, io.sub} = 10'(ns);
                io.out_ready = $urandom_range(3) != 0;
                #1;
                if (io.out_valid && io.out_ready) begin
                    if (q.size() == 0) check({tag, "_extra"}, 0, 1);
                    else check(tag, {io.s, io.cout, io.ovf, io.zero}, q.pop_front());
                    nr++;
                end
                if (io.in_valid && io.in_ready) begin
                    q.push_back(model4(io.a, io.b, io.cin, io.sub));
                    ns++;
                end
            end
            check({tag, "_count"}, nr, 1024);
            n_done++;
        end
    end

    task automatic run_op(input logic [15:0] a, b, input logic ci, su,
                          input logic [15:0] es, input logic ec, eo, ez);
        @(negedge clk);
        io16.a = a;
        io16.b = b;
        io16.cin = ci;
        io16.sub = su;
        io16.in_valid = 1;
        io16.out_ready = 1;
        #1 check("op_rdy", io16.in_ready, 1);
        @(posedge clk);
        for (int j = 0; j < STAGES; j++) begin
            if (j != 0) @(posedge clk);
            @(negedge clk);
            io16.in_valid = 0;
            check("op_lat", io16.out_valid, j == STAGES - 1);
        end
        check("op_s", io16.s, es);
        check("op_cout", io16.cout, ec);
        check("op_ovf", io16.ovf, eo);
        check("op_zero", io16.zero, ez);
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        n_done = 0;
        go_small = 0;
        rst = 1;
        io16.in_valid = 0;
        io16.out_ready = 1;
        {io16.a, io16.b, io16.cin, io16.sub} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;
        #1;
        check("rst_valid", io16.out_valid, 0);
        check("rst_s", io16.s, 0);
        check("rst_cout", io16.cout, 0);
        check("rst_ovf", io16.ovf, 0);
        check("rst_zero", io16.zero, 0);
        check("rst_rdy", io16.in_ready, 1);

        run_op(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
        run_op(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
        run_op(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0);
        run_op(16'h0003, 16'h0005, 1, 1, 16'hFFFE, 0, 0, 0);
        run_op(16'h1234, 16'h0FFF, 1, 0, 16'h2234, 0, 0, 0);
        run_op(16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1, 1);

        sent = 0;
        recv = 0;
        prev_stall = 0;
        held = '0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            @(negedge clk);
            io16.in_valid = sent < 6;
            io16.a = 16'(sent + 1);
            io16.b = 16'((sent + 1) * 16'h1000);
            io16.cin = 0;
            io16.sub = 0;
            io16.out_ready = !(c >= 5 && c <= 7);
            #1;
            if (prev_stall) check("bp_hold", io16.s, held);
            prev_stall = io16.out_valid && !io16.out_ready;
            if (prev_stall) begin
                check("bp_rdy", io16.in_ready, 0);
                held = io16.s;
            end
            if (io16.out_valid && io16.out_ready) begin
                check("bp_s", io16.s, 16'(16'h1001 * (recv + 1)));
                recv++;
            end
            if (io16.in_valid && io16.in_ready) sent++;
        end
        check("bp_count", recv, 6);
        io16.in_valid = 0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            #1 if (io16.out_valid) seen++;
        end
        check("bp_dup", seen, 0);

        io16.out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            io16.in_valid = 1;
            io16.a = 16'(16'h0101 * (i + 1));
            io16.b = 16'h0010;
            #1 check("rf_rdy", io16.in_ready, 1);
        end
        @(negedge clk);
        io16.in_valid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        check("rf_valid", io16.out_valid, 0);
        check("rf_s", io16.s, 0);
        check("rf_cout", io16.cout, 0);
        check("rf_ovf", io16.ovf, 0);
        check("rf_zero", io16.zero, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            #1 if (io16.out_valid) seen++;
        end
        check("rf_ghost", seen, 0);

        go_small = 1;
        for (int i = 0; i < 20000 && n_done < 3; i++) @(posedge clk);
        check("small_done", n_done, 3);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
